// File: rtl/n_term_loopback_bist.sv
// Loopback BIST for the north terminal wires: drives walking-one then LFSR patterns on drv
// and checks the field-reversed echo returning on ret after LOOP_LATENCY cycles.
module n_term_loopback_bist #(
  parameter int LOOP_LATENCY  = 2,
  parameter int PATTERN_COUNT = 256
) (
  input  logic        UserCLK,
  input  logic        resetn,
  input  logic        start,
  output logic [35:0] drv,
  input  logic [35:0] ret,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [35:0] fail_vec
);

  localparam logic [35:0] SEED       = 36'hA5A5A5A5A;
  localparam logic [15:0] WALK_LAST  = 16'd35;
  localparam logic [15:0] PAT_LAST   = 16'(PATTERN_COUNT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(LOOP_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WALK, LFSR, DRAIN, DONE} state_t;

  state_t                              state_q, state_d;
  logic [15:0]                         cnt_q, cnt_d;
  logic [35:0]                         lfsr_q, lfsr_d;
  logic [7:0]                          err_q, err_d;
  logic [35:0]                         fail_q, fail_d;
  logic [LOOP_LATENCY-1:0][35:0]       exp_q, exp_d;
  logic [LOOP_LATENCY-1:0]             vld_q, vld_d;
  logic [35:0]                         diff;

  // Each terminal bundle comes back on the south side with its wire order reversed.
  function automatic logic [35:0] field_rev(input logic [35:0] p);
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)  r[i]      = p[3 - i];
    for (int i = 0; i < 8; i++)  r[4 + i]  = p[11 - i];
    for (int i = 0; i < 8; i++)  r[12 + i] = p[19 - i];
    for (int i = 0; i < 16; i++) r[20 + i] = p[35 - i];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    err_d   = err_q;
    fail_d  = fail_q;
    drv     = '0;
    diff    = ret ^ exp_q[LOOP_LATENCY-1];

    // Compare first so a launching start below takes priority when clearing results.
    if (vld_q[LOOP_LATENCY-1] && (diff != '0)) begin
      err_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      fail_d = fail_q | diff;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WALK;
          cnt_d   = '0;
          lfsr_d  = SEED;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      WALK: begin
        drv   = 36'd1 << cnt_q[5:0];
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == WALK_LAST) begin
          state_d = LFSR;
          cnt_d   = '0;
        end
      end
      LFSR: begin
        drv    = lfsr_q;
        lfsr_d = {lfsr_q[34:0], lfsr_q[35] ^ lfsr_q[24]};
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == PAT_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    exp_d[0] = field_rev(drv);
    vld_d[0] = (state_q == WALK) || (state_q == LFSR);
    for (int i = 1; i < LOOP_LATENCY; i++) begin
      exp_d[i] = exp_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      err_q   <= '0;
      fail_q  <= '0;
      exp_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      exp_q   <= exp_d;
      vld_q   <= vld_d;
    end
  end

  assign busy      = (state_q == WALK) || (state_q == LFSR) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 8'd0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_n_term_loopback_bist.sv
// Scoreboard bench for n_term_loopback_bist: a behavioural loopback drives ret, run results
// are queued at launch and popped by a monitor when done rises.
module tb_n_term_loopback_bist;

  localparam int NPAT = 36 + 256;
  localparam int BUSY_LEN = NPAT + 2;

  logic        UserCLK = 1'b0;
  logic        resetn  = 1'b0;
  logic        start   = 1'b0;
  logic [35:0] drv;
  logic [35:0] ret;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [35:0] fail_vec;

  n_term_loopback_bist #(.LOOP_LATENCY(2), .PATTERN_COUNT(256)) dut (
    .UserCLK  (UserCLK),
    .resetn   (resetn),
    .start    (start),
    .drv      (drv),
    .ret      (ret),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {
    int          err;
    logic [35:0] fail;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          mode  = 0;
  logic [35:0] pat [NPAT];
  logic [35:0] d1 = '0, d2 = '0, d3 = '0;
  int          busy_len  = 0;
  logic        busy_prev = 1'b0;
  logic        done_prev = 1'b0;

  function automatic logic [35:0] field_rev(input logic [35:0] p);
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)  r[i]      = p[3 - i];
    for (int i = 0; i < 8; i++)  r[4 + i]  = p[11 - i];
    for (int i = 0; i < 8; i++)  r[12 + i] = p[19 - i];
    for (int i = 0; i < 16; i++) r[20 + i] = p[35 - i];
    return r;
  endfunction

  // Loopback wiring model: 0 ideal, 1 ret[0] stuck low, 2 inverted, 3 one extra cycle of delay.
  always @(posedge UserCLK) begin
    d1 <= drv;
    d2 <= d1;
    d3 <= d2;
  end

  always_comb begin
    ret = field_rev(d2);
    case (mode)
      1:       ret = field_rev(d2) & ~36'd1;
      2:       ret = ~field_rev(d2);
      3:       ret = field_rev(d3);
      default: ret = field_rev(d2);
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: checks the pattern stream every busy cycle and the result whenever done rises.
  always @(negedge UserCLK) begin
    exp_t e;
    if (busy && !busy_prev) busy_len = 0;
    if (busy) begin
      busy_len++;
      if (busy_len <= NPAT) check("drv_pattern", {28'd0, drv}, {28'd0, pat[busy_len-1]});
      else                  check("drv_drain", {28'd0, drv}, 64'd0);
      if (mode == 3 && busy_len == 39) check("walk_errs", {56'd0, err_count}, 64'd36);
    end
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("err_count", {56'd0, err_count}, 64'(e.err));
        check("fail_vec", {28'd0, fail_vec}, {28'd0, e.fail});
        check("pass", {63'd0, pass}, {63'd0, e.err == 0});
        check("busy_len", 64'(busy_len), 64'(e.len));
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_drv"},  {28'd0, drv}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_pass"}, {63'd0, pass}, 64'd0);
    check({tag, "_err"},  {56'd0, err_count}, 64'd0);
    check({tag, "_fail"}, {28'd0, fail_vec}, 64'd0);
  endtask

  task automatic launch(input int m);
    mode = m;
    @(posedge UserCLK); #1 start = 1'b1;
    @(posedge UserCLK); #1 start = 1'b0;
  endtask

  task automatic run_and_wait(input int m, input exp_t e, input bit repulse);
    bit got = 1'b0;
    sb_q.push_back(e);
    launch(m);
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge UserCLK);
      start = repulse && busy && (busy_len == 50);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("run_completes", {63'd0, got}, 64'd1);
  endtask

  initial begin
    logic [35:0] l, prev, fail_acc;
    int          n;
    exp_t        e;
    bit          hit;

    for (int k = 0; k < 36; k++) pat[k] = 36'd1 << k;
    l = 36'hA5A5A5A5A;
    for (int k = 36; k < NPAT; k++) begin
      pat[k] = l;
      l = {l[34:0], l[35] ^ l[24]};
    end

    repeat (3) @(negedge UserCLK);
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (5) @(negedge UserCLK);
    check("idle_waits", {63'd0, busy}, 64'd0);

    $display("[TB] ideal loopback");
    e = '{err: 0, fail: 36'd0, len: BUSY_LEN};
    run_and_wait(0, e, 1'b0);

    $display("[TB] ret[0] stuck at 0");
    n = 0;
    for (int k = 0; k < NPAT; k++) if (pat[k][3]) n++;
    e = '{err: (n > 255) ? 255 : n, fail: (n > 0) ? 36'd1 : 36'd0, len: BUSY_LEN};
    run_and_wait(1, e, 1'b0);

    $display("[TB] inverted return");
    e = '{err: 255, fail: 36'hFFFFFFFFF, len: BUSY_LEN};
    run_and_wait(2, e, 1'b0);

    $display("[TB] return one cycle late");
    n = 0;
    prev = '0;
    fail_acc = '0;
    for (int k = 0; k < NPAT; k++) begin
      if (pat[k] != prev) begin
        n++;
        fail_acc |= field_rev(pat[k] ^ prev);
      end
      prev = pat[k];
    end
    e = '{err: (n > 255) ? 255 : n, fail: fail_acc, len: BUSY_LEN};
    run_and_wait(3, e, 1'b0);

    $display("[TB] reset mid-run");
    launch(0);
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge UserCLK);
      if (busy && busy_len >= 100) hit = 1'b1;
    end
    check("reached_cycle_100", {63'd0, hit}, 64'd1);
    @(posedge UserCLK); #1 resetn = 1'b0;
    @(negedge UserCLK);
    check_all_zero("abort");
    repeat (3) @(negedge UserCLK);
    resetn = 1'b1;
    repeat (20) @(negedge UserCLK);
    check("abort_no_busy", {63'd0, busy}, 64'd0);
    check("abort_no_done", {63'd0, done}, 64'd0);

    $display("[TB] fresh run after abort");
    e = '{err: 0, fail: 36'd0, len: BUSY_LEN};
    run_and_wait(0, e, 1'b0);

    $display("[TB] start re-pulsed mid-run");
    e = '{err: 0, fail: 36'd0, len: BUSY_LEN};
    run_and_wait(0, e, 1'b1);

    repeat (5) @(negedge UserCLK);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n_term_loopback_bist.md
N_TERM_LOOPBACK_BIST -- requirements
Module: n_term_loopback_bist

Interface
REQ-001 The block SHALL have parameter LOOP_LATENCY, default 2: cycles from a pattern on drv to its return on ret (range 1-8).
REQ-002 The block SHALL have parameter PATTERN_COUNT, default 256: number of LFSR patterns after the walking-one phase (range 1-65535).
REQ-003 The block SHALL have port UserCLK, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: level-sampled run request.
REQ-006 The block SHALL have port drv, output, 36 bits: pattern driven into the north terminal wires. Bits [3:0] drive N1END3..0, [11:4] drive N2MID7..0, [19:12] drive N2END7..0 and [35:20] drive N4END15..0, each field LSB-aligned.
REQ-007 The block SHALL have port ret, input, 36 bits: returning south wires. Bits [3:0] are S1BEG3..0, [11:4] S2BEG7..0, [19:12] S2BEGb7..0 and [35:20] S4BEG15..0, with the same field layout.
REQ-008 The block SHALL have output busy, 1 bit: a run is in progress.
REQ-009 The block SHALL have output done, 1 bit: level signal that the run is complete.
REQ-010 The block SHALL have output pass, 1 bit: equals done AND err_count==0.
REQ-011 The block SHALL have output err_count, 8 bits: mismatching compares, saturating.
REQ-012 The block SHALL have output fail_vec, 36 bits: sticky per-bit mismatch flags in ret bit positions.

Function
REQ-013 The expected value exp(p) of ret for pattern p SHALL be p with each field bit-reversed within the field: ret[i]=p[3-i] for i<4; ret[4+i]=p[11-i] for i<8; ret[12+i]=p[19-i] for i<8; ret[20+i]=p[35-i] for i<16.
REQ-014 The FSM SHALL have the states IDLE, WALK, LFSR, DRAIN and DONE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL enter WALK, clear err_count and fail_vec, drop done, and raise busy.
REQ-016 WALK SHALL present drv=1<<k for k=0..35, one pattern per cycle, in 36 cycles, then go to LFSR.
REQ-017 LFSR SHALL present PATTERN_COUNT consecutive states of a 36-bit Fibonacci LFSR (taps x^36+x^25+1, seed 36'hA5A5A5A5A, shift once per cycle, first pattern = seed), then go to DRAIN.
REQ-018 The pattern counter SHALL be 16 bits.
REQ-019 drv SHALL be all-zero in IDLE, DRAIN and DONE.
REQ-020 A pattern presented during cycle k SHALL be compared against ret sampled at the edge ending cycle k+LOOP_LATENCY.
REQ-021 Expected values SHALL travel in a LOOP_LATENCY-deep shift register with a valid bit, and only valid entries SHALL be compared.
REQ-022 On each mismatch, err_count SHALL increment by 1, saturating at 255.
REQ-023 On each mismatch, fail_vec SHALL be ORed with (ret XOR exp).
REQ-024 DRAIN SHALL last until the last valid compare, then go to DONE.
REQ-025 In DONE, busy=0 and done=1; the FSM SHALL hold until the next start.
REQ-026 busy SHALL be high from the first pattern cycle through the final compare cycle, exactly 36+PATTERN_COUNT+LOOP_LATENCY cycles.
REQ-027 start while busy SHALL be ignored.
REQ-028 start held high through DONE SHALL relaunch the run on the next edge.
REQ-029 ret SHALL be ignored outside valid compare slots.

Reset
REQ-030 While resetn=0, the block SHALL hold the state IDLE with drv=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, pipeline valid bits cleared, and the LFSR at the seed.
REQ-031 resetn asserted mid-run SHALL abort the run immediately, with no done pulse.
REQ-032 After resetn deasserts, the block SHALL wait for start.

Verification
REQ-033 Ideal loopback model (the field reversal of REQ-013 plus a 2-cycle delay), start pulse -> busy for 294 cycles, then done=1, pass=1, err_count=0, fail_vec=0.
REQ-034 Same model with ret[0] stuck at 0 -> done=1, pass=0, fail_vec=36'h000000001, err_count equal to the reference-model count of patterns with p[3]=1 (at least 1).
REQ-035 ret = ~exp throughout the run -> err_count=255 (saturated), fail_vec=36'hFFFFFFFFF, pass=0.
REQ-036 Model delay 3 with LOOP_LATENCY=2 -> pass=0 and err_count>0; the WALK compares alone fail all 36.
REQ-037 resetn pulsed low at cycle 100 of a run -> all outputs zero next cycle, done never rises; a fresh start then gives pass=1 on the ideal model.
REQ-038 start re-pulsed at cycle 50 of a run -> no effect, total busy length still 294 cycles.
